ghost_route_ctrl: RTL and testbench



---
 rtl/ghost_route_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_ghost_route_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ghost_route_ctrl.sv
// Ghost sprite mover: follows a run-time loadable waypoint route one step per frame,
// with wall stall, screen clamping and a timed reversed half-speed frightened mode.
module ghost_route_ctrl #(
  parameter int         START_X       = 176,
  parameter int         START_Y       = 64,
  parameter logic [1:0] START_DIR     = 2'b10,
  parameter int         SIZE          = 16,
  parameter int         STEP          = 1,
  parameter int         NUM_WP        = 8,
  parameter int         TOL           = 2,
  parameter int         X_MAX         = 639,
  parameter int         Y_MAX         = 479,
  parameter int         FRIGHT_FRAMES = 360
) (
  input  logic                      frame_clk,
  input  logic                      Reset,
  input  logic                      enable,
  input  logic                      fright_req,
  input  logic                      wall_l,
  input  logic                      wall_r,
  input  logic                      wall_d,
  input  logic                      wall_u,
  input  logic                      wp_we,
  input  logic [$clog2(NUM_WP)-1:0] wp_addr,
  input  logic [9:0]                wp_x,
  input  logic [9:0]                wp_y,
  input  logic [1:0]                wp_dir,
  output logic [9:0]                ghost_x,
  output logic [9:0]                ghost_y,
  output logic [9:0]                ghost_s,
  output logic [9:0]                x_motion,
  output logic [9:0]                y_motion,
  output logic [1:0]                dir,
  output logic                      frightened,
  output logic [$clog2(NUM_WP)-1:0] wp_idx
);

  localparam int WP_W  = $clog2(NUM_WP);
  localparam int CNT_W = (FRIGHT_FRAMES > 2) ? $clog2(FRIGHT_FRAMES) : 1;
  localparam logic [CNT_W-1:0]     FR_LOAD = CNT_W'(FRIGHT_FRAMES - 1);
  localparam logic [WP_W-1:0]      LAST_WP = WP_W'(NUM_WP - 1);
  localparam logic signed [11:0]   STEP_S  = 12'(STEP);
  localparam logic [10:0]          TOL_U   = 11'(TOL);

  typedef enum logic [1:0] {IDLE, CHASE, FRIGHT} state_t;

  function automatic logic [9:0] clamp_axis(input logic signed [11:0] v, input int lo, input int hi);
    logic signed [11:0] lo_s;
    logic signed [11:0] hi_s;
    logic signed [11:0] r;
    lo_s = 12'(lo);
    hi_s = 12'(hi);
    r    = v;
    if (v < lo_s) r = lo_s;
    else if (v > hi_s) r = hi_s;
    return r[9:0];
  endfunction

  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 11'(-d) : 11'(d);
  endfunction

  logic [9:0] tab_x   [NUM_WP];
  logic [9:0] tab_y   [NUM_WP];
  logic [1:0] tab_dir [NUM_WP];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [9:0]       x_d, y_d, xm_d, ym_d, move_x, move_y;
  logic [1:0]       dir_d;
  logic             fr_d, mode_fright, wall_hit, hit;
  logic [WP_W-1:0]  idx_d;
  logic signed [11:0] px, py;

  assign ghost_s = 10'(SIZE);

  // Table writes are allowed in every state, including IDLE.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_WP; i++) begin
        tab_x[i]   <= '0;
        tab_y[i]   <= '0;
        tab_dir[i] <= '0;
      end
    end else if (wp_we && (32'(wp_addr) < NUM_WP)) begin
      tab_x[wp_addr]   <= wp_x;
      tab_y[wp_addr]   <= wp_y;
      tab_dir[wp_addr] <= wp_dir;
    end
  end

  assign px  = signed'({2'b00, ghost_x});
  assign py  = signed'({2'b00, ghost_y});
  assign hit = (abs_diff(ghost_x, tab_x[wp_idx]) <= TOL_U) &&
               (abs_diff(ghost_y, tab_y[wp_idx]) <= TOL_U);
  assign mode_fright = (state_q == IDLE) ? frightened : (state_q == FRIGHT);

  always_comb begin
    move_x   = ghost_x;
    move_y   = ghost_y;
    wall_hit = 1'b0;
    unique case (dir)
      2'b00: begin move_x = clamp_axis(px - STEP_S, SIZE, X_MAX - SIZE); wall_hit = wall_l; end
      2'b01: begin move_x = clamp_axis(px + STEP_S, SIZE, X_MAX - SIZE); wall_hit = wall_r; end
      2'b10: begin move_y = clamp_axis(py + STEP_S, SIZE, Y_MAX - SIZE); wall_hit = wall_d; end
      default: begin move_y = clamp_axis(py - STEP_S, SIZE, Y_MAX - SIZE); wall_hit = wall_u; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = ghost_x;
    y_d     = ghost_y;
    xm_d    = x_motion;
    ym_d    = y_motion;
    dir_d   = dir;
    fr_d    = frightened;
    cnt_d   = cnt_q;
    idx_d   = wp_idx;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      xm_d = '0;
      ym_d = '0;
      if (!mode_fright) begin
        state_d = CHASE;
        if (fright_req) begin
          state_d = FRIGHT;
          fr_d    = 1'b1;
          dir_d   = {dir[1], ~dir[0]};
          cnt_d   = FR_LOAD;
        end else if (hit) begin
          x_d   = clamp_axis(signed'({2'b00, tab_x[wp_idx]}), SIZE, X_MAX - SIZE);
          y_d   = clamp_axis(signed'({2'b00, tab_y[wp_idx]}), SIZE, Y_MAX - SIZE);
          dir_d = tab_dir[wp_idx];
          idx_d = (wp_idx == LAST_WP) ? '0 : wp_idx + 1'b1;
        end else if (!wall_hit) begin
          x_d  = move_x;
          y_d  = move_y;
          xm_d = move_x - ghost_x;
          ym_d = move_y - ghost_y;
        end
      end else begin
        state_d = FRIGHT;
        // Half speed: only frames with an even pre-edge counter move.
        if (!cnt_q[0] && !wall_hit) begin
          x_d  = move_x;
          y_d  = move_y;
          xm_d = move_x - ghost_x;
          ym_d = move_y - ghost_y;
        end
        if (fright_req) begin
          cnt_d = FR_LOAD;
        end else if (cnt_q == '0) begin
          state_d = CHASE;
          fr_d    = 1'b0;
          dir_d   = {dir[1], ~dir[0]};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= CHASE;
      cnt_q      <= '0;
      ghost_x    <= 10'(START_X);
      ghost_y    <= 10'(START_Y);
      x_motion   <= '0;
      y_motion   <= '0;
      dir        <= START_DIR;
      frightened <= 1'b0;
      wp_idx     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ghost_x    <= x_d;
      ghost_y    <= y_d;
      x_motion   <= xm_d;
      y_motion   <= ym_d;
      dir        <= dir_d;
      frightened <= fr_d;
      wp_idx     <= idx_d;
    end
  end

endmodule

// File: tb/tb_ghost_route_ctrl.sv
// Directed bench for ghost_route_ctrl: route capture and wrap, wall stall, idle hold,
// frightened timing/reload/priority, clamping and asynchronous reset.
module tb_ghost_route_ctrl;

  logic frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  logic       Reset, enable, fright_req, wall_l, wall_r, wall_d, wall_u, wp_we;
  logic [0:0] wp_addr;
  logic [9:0] wp_x, wp_y;
  logic [1:0] wp_dir;
  logic [9:0] gx, gy, gs, xm, ym;
  logic [1:0] gdir;
  logic       gfr;
  logic [0:0] gidx;

  logic       c_en, c_zero;
  logic [2:0] c_addr;
  logic [9:0] c_zero10;
  logic [1:0] c_zero2;
  logic [9:0] cx, cy, cs, cxm, cym;
  logic [1:0] cdir;
  logic       cfr;
  logic [2:0] cidx;

  int checks = 0;
  int errors = 0;

  ghost_route_ctrl #(.NUM_WP(2), .FRIGHT_FRAMES(4)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .enable(enable), .fright_req(fright_req),
    .wall_l(wall_l), .wall_r(wall_r), .wall_d(wall_d), .wall_u(wall_u),
    .wp_we(wp_we), .wp_addr(wp_addr), .wp_x(wp_x), .wp_y(wp_y), .wp_dir(wp_dir),
    .ghost_x(gx), .ghost_y(gy), .ghost_s(gs), .x_motion(xm), .y_motion(ym),
    .dir(gdir), .frightened(gfr), .wp_idx(gidx)
  );

  ghost_route_ctrl #(.START_Y(462)) dut_c (
    .frame_clk(frame_clk), .Reset(Reset), .enable(c_en), .fright_req(c_zero),
    .wall_l(c_zero), .wall_r(c_zero), .wall_d(c_zero), .wall_u(c_zero),
    .wp_we(c_zero), .wp_addr(c_addr), .wp_x(c_zero10), .wp_y(c_zero10), .wp_dir(c_zero2),
    .ghost_x(cx), .ghost_y(cy), .ghost_s(cs), .x_motion(cxm), .y_motion(cym),
    .dir(cdir), .frightened(cfr), .wp_idx(cidx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; enable = 1'b0; fright_req = 1'b0;
    wall_l = 1'b0; wall_r = 1'b0; wall_d = 1'b0; wall_u = 1'b0;
    wp_we = 1'b0; wp_addr = '0; wp_x = '0; wp_y = '0; wp_dir = '0;
    c_en = 1'b0; c_zero = 1'b0; c_addr = '0; c_zero10 = '0; c_zero2 = '0;
    #12;
    chk("rst_x", gx, 176); chk("rst_y", gy, 64); chk("rst_dir", gdir, 2);
    chk("rst_xm", xm, 0); chk("rst_ym", ym, 0); chk("rst_fr", gfr, 0);
    chk("rst_idx", gidx, 0); chk("rst_s", gs, 16); chk("rst_cy", cy, 462);
    Reset = 1'b0;

    // Load the two-waypoint loop while frozen.
    wp_we = 1'b1; wp_addr = 1'd0; wp_x = 10'd176; wp_y = 10'd96; wp_dir = 2'b01;
    step();
    wp_addr = 1'd1; wp_x = 10'd190; wp_y = 10'd96; wp_dir = 2'b00;
    step();
    wp_we = 1'b0;
    chk("idle_hold_y", gy, 64);

    // Clamp at the bottom edge.
    c_en = 1'b1;
    step(); chk("clamp_y1", cy, 463); chk("clamp_ym1", cym, 1);
    step(); chk("clamp_y2", cy, 463); chk("clamp_ym2", cym, 0);
    c_en = 1'b0;

    // Straight run down to wp0.
    enable = 1'b1;
    step(); chk("run_y1", gy, 65); chk("run_ym1", ym, 1); chk("run_xm1", xm, 0);
    repeat (29) step();
    chk("run_y94", gy, 94);
    step(); chk("cap0_y", gy, 96); chk("cap0_x", gx, 176); chk("cap0_dir", gdir, 1);
    chk("cap0_idx", gidx, 1); chk("cap0_ym", ym, 0);
    step(); chk("after_cap_x", gx, 177); chk("after_cap_xm", xm, 1);

    // Wrap: wp1 then back to wp0.
    repeat (11) step(); chk("to_wp1_x", gx, 188);
    step(); chk("cap1_x", gx, 190); chk("cap1_dir", gdir, 0); chk("cap1_idx", gidx, 0);
    repeat (12) step(); chk("to_wp0_x", gx, 178);
    step(); chk("recap0_x", gx, 176); chk("recap0_dir", gdir, 1); chk("recap0_idx", gidx, 1);

    // Wall stall heading right.
    wall_r = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); chk("stall_x", gx, 176); chk("stall_xm", xm, 0);
    end
    wall_r = 1'b0; wall_l = 1'b1;
    step(); chk("resume_x", gx, 177); chk("resume_xm", xm, 1);
    wall_l = 1'b0;
    step(); chk("resume2_x", gx, 178);

    // Freeze holds everything, including the last motion.
    enable = 1'b0;
    repeat (3) step();
    chk("freeze_x", gx, 178); chk("freeze_xm", xm, 1);
    enable = 1'b1;

    // Frightened: reversed, moves on 2 of 4 frames, then reverts.
    fright_req = 1'b1;
    step(); fright_req = 1'b0;
    chk("fr_dir", gdir, 0); chk("fr_on", gfr, 1); chk("fr_entry_x", gx, 178); chk("fr_entry_xm", xm, 0);
    step(); chk("fr_c3_x", gx, 178);
    step(); chk("fr_c2_x", gx, 177); chk("fr_c2_xm", xm, 10'h3FF);
    step(); chk("fr_c1_x", gx, 177);
    step(); chk("fr_c0_x", gx, 176); chk("fr_exit", gfr, 0); chk("fr_exit_dir", gdir, 1);

    // Reload during fright does not reverse again.
    fright_req = 1'b1;
    step(); fright_req = 1'b0; chk("rl_dir", gdir, 0);
    step(); chk("rl_b_x", gx, 176);
    fright_req = 1'b1;
    step(); fright_req = 1'b0; chk("rl_c_x", gx, 175); chk("rl_c_dir", gdir, 0); chk("rl_c_fr", gfr, 1);
    step(); step(); chk("rl_e_x", gx, 174);
    step(); chk("rl_f_fr", gfr, 1);
    step(); chk("rl_g_x", gx, 173); chk("rl_g_fr", gfr, 0); chk("rl_g_dir", gdir, 1);

    // Fright request beats a capture on the same edge.
    repeat (15) step(); chk("pri_pre_x", gx, 188);
    fright_req = 1'b1;
    step(); fright_req = 1'b0;
    chk("pri_x", gx, 188); chk("pri_idx", gidx, 1); chk("pri_dir", gdir, 0); chk("pri_fr", gfr, 1);
    repeat (4) step();
    chk("pri_end_x", gx, 186); chk("pri_end_dir", gdir, 1); chk("pri_end_fr", gfr, 0); chk("pri_end_idx", gidx, 1);

    // Writing the sought entry on a capture edge: capture uses the old entry.
    step(); step(); chk("wr_pre_x", gx, 188);
    wp_we = 1'b1; wp_addr = 1'd1; wp_x = 10'd300; wp_y = 10'd300; wp_dir = 2'b11;
    step(); wp_we = 1'b0;
    chk("wr_cap_x", gx, 190); chk("wr_cap_y", gy, 96); chk("wr_cap_dir", gdir, 0); chk("wr_cap_idx", gidx, 0);
    chk("wr_tab_x", dut.tab_x[1], 300);
    step(); chk("wr_next_x", gx, 189);

    // Asynchronous reset in the middle of fright.
    fright_req = 1'b1;
    step(); fright_req = 1'b0;
    step(); chk("mid_fr", gfr, 1);
    #3 Reset = 1'b1;
    #1;
    chk("arst_x", gx, 176); chk("arst_y", gy, 64); chk("arst_dir", gdir, 2);
    chk("arst_xm", xm, 0); chk("arst_ym", ym, 0); chk("arst_fr", gfr, 0); chk("arst_idx", gidx, 0);
    chk("arst_tab_x", dut.tab_x[1], 0); chk("arst_tab_y", dut.tab_y[1], 0); chk("arst_tab_dir", dut.tab_dir[1], 0);
    step();
    Reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
